// File: rtl/fml_arb2.sv
// rtl/fml_arb2.sv - two-master round-robin arbiter in front of the hpdmc FML burst port
module fml_arb2 #(
  parameter int ADR_W = 26,
  parameter int DAT_W = 16,
  parameter int SEL_W = 2,
  parameter int BURST = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [ADR_W-1:0] m0_adr,
  input  logic             m0_stb,
  input  logic             m0_we,
  input  logic [SEL_W-1:0] m0_sel,
  input  logic [DAT_W-1:0] m0_do,
  output logic [DAT_W-1:0] m0_di,
  output logic             m0_ack,
  input  logic [ADR_W-1:0] m1_adr,
  input  logic             m1_stb,
  input  logic             m1_we,
  input  logic [SEL_W-1:0] m1_sel,
  input  logic [DAT_W-1:0] m1_do,
  output logic [DAT_W-1:0] m1_di,
  output logic             m1_ack,
  output logic [ADR_W-1:0] s_adr,
  output logic             s_stb,
  output logic             s_we,
  output logic [SEL_W-1:0] s_sel,
  output logic [DAT_W-1:0] s_do,
  input  logic [DAT_W-1:0] s_di,
  input  logic             s_ack,
  output logic [1:0]       grant_o,
  output logic             busy_o
);

  localparam int CNT_W = $clog2(BURST) + 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t           state, state_nxt;
  logic             gnt, gnt_nxt;
  logic             last, last_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sel_m1;
  logic             gnt_stb;

  // state, grant, fairness and beat counter registers; last=1 lets m0 win the first tie
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      gnt   <= 1'b0;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // arbitration in IDLE, address handshake in ADDR, beat countdown in DATA
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    last_nxt  = last;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (m0_stb || m1_stb) begin
          gnt_nxt   = (m0_stb && m1_stb) ? ~last : m1_stb;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        if (s_ack) begin
          if (BURST == 1) begin
            state_nxt = IDLE;
            last_nxt  = gnt;
          end else begin
            cnt_nxt   = CNT_W'(BURST - 1);
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          state_nxt = IDLE;
          last_nxt  = gnt;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // steering: master 0 drives the slave side while idle, the registered grant otherwise
  always_comb begin
    sel_m1  = (state != IDLE) && gnt;
    gnt_stb = sel_m1 ? m1_stb : m0_stb;
    s_stb   = (state == ADDR) && gnt_stb;
    s_adr   = sel_m1 ? m1_adr : m0_adr;
    s_we    = s_stb && (sel_m1 ? m1_we : m0_we);
    s_sel   = sel_m1 ? m1_sel : m0_sel;
    s_do    = sel_m1 ? m1_do : m0_do;
    m0_ack  = (state == ADDR) && !gnt && s_ack;
    m1_ack  = (state == ADDR) && gnt && s_ack;
    m0_di   = s_di;
    m1_di   = s_di;
    grant_o = (state == IDLE) ? 2'b00 : (gnt ? 2'b10 : 2'b01);
    busy_o  = (state != IDLE);
  end

endmodule

// File: tb/tb_fml_arb2.sv
// tb/tb_fml_arb2.sv - randomized self-checking bench for fml_arb2
module tb_fml_arb2;

  localparam int BURST = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [25:0] m0_adr, m1_adr;
  logic        m0_stb, m1_stb, m0_we, m1_we;
  logic [1:0]  m0_sel, m1_sel;
  logic [15:0] m0_do, m1_do, s_di;
  logic        s_ack;

  logic [15:0] m0_di, m1_di, s_do;
  logic        m0_ack, m1_ack, s_stb, s_we, busy_o;
  logic [25:0] s_adr;
  logic [1:0]  s_sel, grant_o;

  logic [15:0] b_m0_di, b_m1_di, b_s_do;
  logic        b_m0_ack, b_m1_ack, b_s_stb, b_s_we, b_busy;
  logic [25:0] b_s_adr;
  logic [1:0]  b_s_sel, b_grant;

  int total = 0;
  int bad = 0;
  int model_last = 1;

  fml_arb2 #(.ADR_W(26), .DAT_W(16), .SEL_W(2), .BURST(BURST)) u_dut (
    .sys_clk(clk), .sys_rst(rst),
    .m0_adr(m0_adr), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel), .m0_do(m0_do),
    .m0_di(m0_di), .m0_ack(m0_ack),
    .m1_adr(m1_adr), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel), .m1_do(m1_do),
    .m1_di(m1_di), .m1_ack(m1_ack),
    .s_adr(s_adr), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel), .s_do(s_do),
    .s_di(s_di), .s_ack(s_ack), .grant_o(grant_o), .busy_o(busy_o)
  );

  fml_arb2 #(.ADR_W(26), .DAT_W(16), .SEL_W(2), .BURST(1)) u_dut_b1 (
    .sys_clk(clk), .sys_rst(rst),
    .m0_adr(m0_adr), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel), .m0_do(m0_do),
    .m0_di(b_m0_di), .m0_ack(b_m0_ack),
    .m1_adr(m1_adr), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel), .m1_do(m1_do),
    .m1_di(b_m1_di), .m1_ack(b_m1_ack),
    .s_adr(b_s_adr), .s_stb(b_s_stb), .s_we(b_s_we), .s_sel(b_s_sel), .s_do(b_s_do),
    .s_di(s_di), .s_ack(s_ack), .grant_o(b_grant), .busy_o(b_busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // round-robin rule: a lone requester wins, a tie goes to whoever was not served last
  function automatic int pick(input logic r0, input logic r1);
    if (r0 && r1) return 1 - model_last;
    return r1 ? 1 : 0;
  endfunction

  // one whole transaction for an already-arbitrated owner: d wait cycles, ack, BURST-1 beats, idle gap
  task automatic do_burst(input int owner, input int d, input bit keep, input bit drop_ok,
                          input int raise_k, input logic [15:0] base);
    logic [1:0]  eg;
    logic [15:0] v;
    logic        es, ewe;
    eg = (owner == 1) ? 2'b10 : 2'b01;
    for (int i = 0; i <= d; i++) begin
      @(negedge clk);
      s_ack = (i == d);
      s_di  = 16'($urandom);
      v     = (i == d) ? base : 16'($urandom);
      es    = (i == d) || !drop_ok || ($urandom_range(0, 1) == 1);
      if (owner == 1) begin m1_stb = es; m1_do = v; m0_do = ~v; end
      else begin m0_stb = es; m0_do = v; m1_do = ~v; end
      ewe = es && ((owner == 1) ? m1_we : m0_we);
      #1;
      total++; if (grant_o !== eg) begin bad++; $display("FAIL addr_grant got=%b exp=%b", grant_o, eg); end
      total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL addr_busy got=%b exp=1", busy_o); end
      total++; if (s_stb !== es) begin bad++; $display("FAIL addr_stb got=%b exp=%b", s_stb, es); end
      total++; if (s_adr !== ((owner == 1) ? m1_adr : m0_adr)) begin bad++; $display("FAIL addr_adr got=%h exp=%h", s_adr, (owner == 1) ? m1_adr : m0_adr); end
      total++; if (s_we !== ewe) begin bad++; $display("FAIL addr_we got=%b exp=%b", s_we, ewe); end
      total++; if (s_sel !== ((owner == 1) ? m1_sel : m0_sel)) begin bad++; $display("FAIL addr_sel got=%b exp=%b", s_sel, (owner == 1) ? m1_sel : m0_sel); end
      total++; if (s_do !== v) begin bad++; $display("FAIL addr_do got=%h exp=%h", s_do, v); end
      total++; if (m0_ack !== 1'(owner == 0 && i == d)) begin bad++; $display("FAIL addr_m0_ack got=%b exp=%b", m0_ack, owner == 0 && i == d); end
      total++; if (m1_ack !== 1'(owner == 1 && i == d)) begin bad++; $display("FAIL addr_m1_ack got=%b exp=%b", m1_ack, owner == 1 && i == d); end
      total++; if (m0_di !== s_di || m1_di !== s_di) begin bad++; $display("FAIL read_fanout got=%h/%h exp=%h", m0_di, m1_di, s_di); end
    end
    for (int k = 1; k < BURST; k++) begin
      @(negedge clk);
      s_ack = 1'($urandom);
      v     = base + 16'(k);
      if (owner == 1) begin
        m1_do = v; m0_do = ~v;
        if (!keep) m1_stb = 1'b0;
        if (k == raise_k) m0_stb = 1'b1;
        m1_adr = 26'($urandom); m1_we = 1'($urandom); m1_sel = 2'($urandom);
      end else begin
        m0_do = v; m1_do = ~v;
        if (!keep) m0_stb = 1'b0;
        if (k == raise_k) m1_stb = 1'b1;
        m0_adr = 26'($urandom); m0_we = 1'($urandom); m0_sel = 2'($urandom);
      end
      #1;
      total++; if (grant_o !== eg) begin bad++; $display("FAIL data_grant beat=%0d got=%b exp=%b", k, grant_o, eg); end
      total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL data_busy beat=%0d got=%b exp=1", k, busy_o); end
      total++; if (s_stb !== 1'b0 || s_we !== 1'b0) begin bad++; $display("FAIL data_stb_we beat=%0d got=%b%b exp=00", k, s_stb, s_we); end
      total++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin bad++; $display("FAIL data_ack beat=%0d got=%b%b exp=00", k, m1_ack, m0_ack); end
      total++; if (s_do !== v) begin bad++; $display("FAIL data_do beat=%0d got=%h exp=%h", k, s_do, v); end
    end
    model_last = owner;
    @(negedge clk);
    s_ack = 1'($urandom);
    #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy_o); end
    total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL idle_grant got=%b exp=00", grant_o); end
    total++; if (s_stb !== 1'b0) begin bad++; $display("FAIL idle_stb got=%b exp=0", s_stb); end
    total++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin bad++; $display("FAIL idle_ack got=%b%b exp=00", m1_ack, m0_ack); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; s_ack = 1'b1; m0_stb = 1'b1; m1_stb = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    total++; if (busy_o !== 1'b0 || b_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b/%b exp=0", busy_o, b_busy); end
    total++; if (grant_o !== 2'b00 || b_grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b/%b exp=00", grant_o, b_grant); end
    total++; if (s_stb !== 1'b0 || b_s_stb !== 1'b0) begin bad++; $display("FAIL reset_stb got=%b/%b exp=0", s_stb, b_s_stb); end
    total++; if (s_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", s_we); end
    total++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b%b exp=00", m1_ack, m0_ack); end
    rst = 1'b0; s_ack = 1'b0; m0_stb = 1'b0; m1_stb = 1'b0;
    model_last = 1;
  endtask

  task automatic test_single_read();
    test_reset();
    m0_adr = 26'h0001234; m0_we = 1'b0; m0_sel = 2'b11; m0_stb = 1'b1;
    #1;
    total++; if (s_stb !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL latency_idle got=%b%b exp=00", s_stb, busy_o); end
    do_burst(pick(m0_stb, m1_stb), 3, 1'b0, 1'b0, -1, 16'($urandom));
  endtask

  task automatic test_simultaneous();
    test_reset();
    m0_adr = 26'($urandom); m1_adr = 26'($urandom);
    m0_stb = 1'b1; m1_stb = 1'b1;
    for (int n = 0; n < 4; n++)
      do_burst(pick(m0_stb, m1_stb), $urandom_range(0, 3), 1'b1, 1'b0, -1, 16'($urandom));
    m0_stb = 1'b0; m1_stb = 1'b0;
  endtask

  task automatic test_write_steer();
    test_reset();
    m1_adr = 26'($urandom); m1_we = 1'b1; m1_sel = 2'b10; m1_stb = 1'b1;
    do_burst(pick(m0_stb, m1_stb), 1, 1'b0, 1'b0, -1, 16'hA000);
  endtask

  task automatic test_request_during_burst();
    test_reset();
    m0_adr = 26'h0000100; m1_adr = 26'h2000200; m0_stb = 1'b1;
    do_burst(pick(m0_stb, m1_stb), 1, 1'b0, 1'b0, 3, 16'($urandom));
    do_burst(pick(m0_stb, m1_stb), 2, 1'b0, 1'b0, -1, 16'($urandom));
  endtask

  task automatic test_stb_drop();
    test_reset();
    m1_adr = 26'($urandom); m1_stb = 1'b1;
    do_burst(pick(m0_stb, m1_stb), 4, 1'b0, 1'b1, -1, 16'($urandom));
  endtask

  task automatic test_reset_mid();
    test_reset();
    m0_adr = 26'($urandom); m0_stb = 1'b1;
    @(negedge clk); s_ack = 1'b1;
    @(negedge clk); s_ack = 1'b0; m0_stb = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); s_ack = 1'b1; m1_stb = 1'b1;
    #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy_o); end
    total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL midrst_grant got=%b exp=00", grant_o); end
    total++; if (s_stb !== 1'b0) begin bad++; $display("FAIL midrst_stb got=%b exp=0", s_stb); end
    total++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin bad++; $display("FAIL midrst_ack got=%b%b exp=00", m1_ack, m0_ack); end
    rst = 1'b0; s_ack = 1'b0; model_last = 1;
    m1_adr = 26'($urandom);
    do_burst(pick(m0_stb, m1_stb), 1, 1'b0, 1'b0, -1, 16'($urandom));
  endtask

  task automatic test_random();
    int r;
    test_reset();
    for (int n = 0; n < 10; n++) begin
      if (!m0_stb && !m1_stb) begin
        r = $urandom_range(1, 3);
        m0_stb = r[0]; m1_stb = r[1];
      end
      do_burst(pick(m0_stb, m1_stb), $urandom_range(0, 3), 1'($urandom), 1'b1,
               $urandom_range(0, BURST - 1), 16'($urandom));
    end
    m0_stb = 1'b0; m1_stb = 1'b0;
  endtask

  task automatic test_burst1();
    int lastb, owner, d;
    logic [1:0] eg;
    test_reset();
    lastb = 1;
    m0_adr = 26'($urandom); m1_adr = 26'($urandom);
    m0_stb = 1'b1; m1_stb = 1'b1;
    for (int n = 0; n < 4; n++) begin
      owner = 1 - lastb;
      eg = (owner == 1) ? 2'b10 : 2'b01;
      d = $urandom_range(0, 2);
      for (int i = 0; i <= d; i++) begin
        @(negedge clk);
        s_ack = (i == d);
        #1;
        total++; if (b_grant !== eg) begin bad++; $display("FAIL b1_grant got=%b exp=%b", b_grant, eg); end
        total++; if (b_s_stb !== 1'b1) begin bad++; $display("FAIL b1_stb got=%b exp=1", b_s_stb); end
        total++; if (b_s_adr !== ((owner == 1) ? m1_adr : m0_adr)) begin bad++; $display("FAIL b1_adr got=%h exp=%h", b_s_adr, (owner == 1) ? m1_adr : m0_adr); end
        total++; if (b_m0_ack !== 1'(owner == 0 && i == d) || b_m1_ack !== 1'(owner == 1 && i == d)) begin bad++; $display("FAIL b1_ack got=%b%b", b_m1_ack, b_m0_ack); end
      end
      @(negedge clk);
      s_ack = 1'b0;
      #1;
      total++; if (b_busy !== 1'b0 || b_grant !== 2'b00) begin bad++; $display("FAIL b1_no_data got=%b/%b exp=0/00", b_busy, b_grant); end
      lastb = owner;
    end
    m0_stb = 1'b0; m1_stb = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_ack = 1'b0; s_di = '0;
    m0_adr = '0; m0_stb = 1'b0; m0_we = 1'b0; m0_sel = '0; m0_do = '0;
    m1_adr = '0; m1_stb = 1'b0; m1_we = 1'b0; m1_sel = '0; m1_do = '0;
    test_reset();
    test_single_read();
    test_simultaneous();
    test_write_steer();
    test_request_during_burst();
    test_stb_drop();
    test_reset_mid();
    test_random();
    test_burst1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
